// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - host/transmitter-side signal bundle for the UART TX feeder
interface uart_tx_feeder_if #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DBIT-1:0]   wr_data;
    logic              enable;
    logic              clr_overflow;
    logic              tx_done_tick;
    logic              tx_start;
    logic [DBIT-1:0]   tx_din;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              overflow;

    modport master (
        output wr_en, wr_data, enable, clr_overflow, tx_done_tick,
        input  tx_start, tx_din, full, empty, count, busy, overflow
    );

    modport slave (
        input  wr_en, wr_data, enable, clr_overflow, tx_done_tick,
        output tx_start, tx_din, full, empty, count, busy, overflow
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO plus one-frame-at-a-time launch control for a UART transmitter
module uart_tx_feeder #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_feeder_if.slave   bus
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [DBIT-1:0]    r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_tx_start;
    logic [DBIT-1:0]    r_tx_din;
    logic               r_overflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_accept;
    logic               w_launch;

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = bus.wr_en & ~w_full;

    // A launch pops the head byte; the next one waits for the transmitter's done tick.
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.enable && !w_empty) begin
                    w_launch     = 1'b1;
                    w_state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_start <= 1'b0;
            r_tx_din   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_launch) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_tx_din <= r_mem[r_rd_ptr];
            end
            r_tx_start <= w_launch;

            case ({w_wr_accept, w_launch})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            // A dropped write wins over a clear arriving in the same cycle.
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.tx_start = r_tx_start;
    assign bus.tx_din   = r_tx_din;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.busy     = (r_state != IDLE) | ~w_empty;
    assign bus.overflow = r_overflow;
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte queue and launch controller directly upstream of the UART transmitter.
- Buffers bytes written by the host or bus side in a synchronous FIFO.
- Launches one transmission at a time by pulsing tx_start with the head byte on tx_din.
- Frees the transmitter for the next byte only after it reports tx_done_tick, so the serializer never receives tx_start mid-frame.

Parameters:
- DBIT, 8, data byte width; must match transmitter data width.
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (default 16 entries).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- wr_en  input  1  write strobe; one byte enqueued per cycle when high and not full.
- wr_data  input  DBIT  byte to enqueue.
- enable  input  1  launch permit; when low, queued bytes are held (no new tx_start), writes still accepted.
- clr_overflow  input  1  clears sticky overflow flag.
- tx_done_tick  input  1  one-cycle pulse from transmitter at end of stop bit.
- tx_start  output  1  one-cycle launch pulse to transmitter.
- tx_din  output  DBIT  byte to transmitter; valid whenever tx_start is high and held until next launch.
- full  output  1  count == 2**ADDR_W.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  number of queued bytes, excluding the byte in flight.
- busy  output  1  high when the FSM is not IDLE or the FIFO is not empty.
- overflow  output  1  sticky; set by a write attempted while full.

Behaviour:
- Reset: clk and rst as already decided, rst asynchronous active-high. On reset:
  - state = IDLE; read pointer, write pointer and count = 0.
  - tx_start = 0, tx_din = 0, overflow = 0; hence full = 0, empty = 1, busy = 0.
  - FIFO array contents are not reset.
- Reset mid-operation: all queued bytes and the in-flight byte are discarded. The transmitter shares rst and aborts too.
- tx_start and tx_din are registered outputs, with no combinational paths from inputs.
- FIFO write:
  - At a clk edge with wr_en=1 and full=0: mem[wr_ptr] <= wr_data; wr_ptr increments and wraps modulo depth.
  - full is evaluated on the pre-edge count. A write while full is dropped and sets overflow, even if a pop occurs in the same cycle.
- FIFO pop: occurs only on a launch (see IDLE below); rd_ptr increments and wraps modulo depth.
- count: next = count + write_accepted - pop. Simultaneous write and pop leaves count unchanged and is legal at any level except full-drop.
- overflow: set has priority over clr_overflow in the same cycle.
- FSM has two states:
  - IDLE: if enable=1 and count != 0, then next edge:
    - tx_start <= 1, tx_din <= mem[rd_ptr];
    - pop;
    - state <= WAIT_DONE.
    - Otherwise tx_start <= 0.
  - WAIT_DONE: tx_start <= 0 (pulse is exactly one cycle). On tx_done_tick=1, state <= IDLE; the next launch can occur no earlier than the edge after return to IDLE.
- tx_done_tick received while in IDLE is ignored.
- enable dropping while in WAIT_DONE does not abort; the in-flight byte completes, then no further launch occurs.
- Latency: a write accepted at edge E into an empty FIFO while IDLE and enabled causes tx_start high for the cycle following edge E+1.
- Ordering: strictly FIFO; bytes leave in write order with no duplication and no loss except dropped overflow writes.
- Wrap-around: pointers wrap silently. count distinguishes full from empty, using width ADDR_W+1.

Test Plan:
- Single byte:
  - After reset, write 0xA5 at edge E -> tx_start high exactly one cycle after edge E+1, with tx_din=0xA5.
  - count returns to 0 and busy stays 1 until tx_done_tick, then drops to 0.
- Burst ordering: write 0x01..0x05 back-to-back; respond with tx_done_tick 10 cycles after each tx_start -> five tx_start pulses carrying 0x01..0x05 in order, none issued before the prior tx_done_tick.
- Full and overflow:
  - enable=0, write 17 bytes -> full=1 and count=16 after the 16th write; the 17th is dropped and overflow=1.
  - Pulse clr_overflow -> overflow=0; the contents drain correctly once enable=1.
- Wrap and simultaneous events: with enable=1, run 40 random bytes with writes coinciding with launch pops -> count correct every cycle and output sequence equals input sequence across multiple pointer wraps.
- Spurious and pause:
  - tx_done_tick while IDLE and empty -> no state change.
  - enable dropped during WAIT_DONE -> the current frame completes; no further tx_start until enable=1.
- Reset mid-frame: assert rst asynchronously in WAIT_DONE with 3 bytes queued -> outputs immediately tx_start=0, tx_din=0, count=0, empty=1, busy=0; no stale byte launched after release.
